// File: rtl/bpfvm_ctrl_mc_if.sv
// Control bundle between the multi-cycle BPF VM controller and its memories/datapath.
// master: controller side (drives selects, enables, strobes, verdict); slave: datapath/memory side.
// Carries opcode, ALU flags, RET operand tests, memory valids, verdict ack and instruction count.
interface bpfvm_ctrl_mc_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      opcode;
    logic             set;
    logic             eq;
    logic             gt;
    logic             ge;
    logic             A_is_zero;
    logic             X_is_zero;
    logic             imm_is_zero;
    logic             mem_ready;
    logic             inst_mem_valid;
    logic             packet_mem_valid;
    logic             verdict_ack;
    logic [2:0]       A_sel;
    logic [2:0]       X_sel;
    logic [1:0]       PC_sel;
    logic             addr_sel;
    logic             B_sel;
    logic             regfile_sel;
    logic [3:0]       ALU_sel;
    logic [1:0]       transfer_sz;
    logic             A_en;
    logic             X_en;
    logic             PC_en;
    logic             PC_rst;
    logic             regfile_wr_en;
    logic             inst_mem_rd_en;
    logic             packet_mem_rd_en;
    logic             accept;
    logic             reject;
    logic             overrun;
    logic             mem_err;
    logic [CNT_W-1:0] insn_count;

    modport master (
        input  opcode, set, eq, gt, ge, A_is_zero, X_is_zero, imm_is_zero,
               mem_ready, inst_mem_valid, packet_mem_valid, verdict_ack,
        output A_sel, X_sel, PC_sel, addr_sel, B_sel, regfile_sel, ALU_sel, transfer_sz,
               A_en, X_en, PC_en, PC_rst, regfile_wr_en, inst_mem_rd_en, packet_mem_rd_en,
               accept, reject, overrun, mem_err, insn_count
    );

    modport slave (
        output opcode, set, eq, gt, ge, A_is_zero, X_is_zero, imm_is_zero,
               mem_ready, inst_mem_valid, packet_mem_valid, verdict_ack,
        input  A_sel, X_sel, PC_sel, addr_sel, B_sel, regfile_sel, ALU_sel, transfer_sz,
               A_en, X_en, PC_en, PC_rst, regfile_wr_en, inst_mem_rd_en, packet_mem_rd_en,
               accept, reject, overrun, mem_err, insn_count
    );
endinterface

// File: rtl/bpfvm_ctrl_mc.sv
// Multi-cycle BPF VM control FSM with instruction budget, packet-memory timeout and held verdict.
// Latency (1-cycle memories): reg/store/jump 3, ALU 4, packet load 4, cond jump 3 (4 if PESSIMISTIC).
// Backpressure: waits indefinitely on inst_mem_valid, MEM_TIMEOUT cycles on packet_mem_valid; verdict held until verdict_ack.
// Ports: clk, rst_n (async active-low), bus = bpfvm_ctrl_mc_if.master (opcode/flags in, datapath controls and verdict out).
module bpfvm_ctrl_mc #(
    parameter int PESSIMISTIC = 0,
    parameter int CNT_W       = 16,
    parameter int MAX_INSNS   = 4096,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst_n,
    bpfvm_ctrl_mc_if.master  bus
);
    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE, S_PMEM_WAIT, S_WRITE_ALU, S_COND_JMP, S_DONE
    } state_t;

    localparam logic [2:0] C_LD = 3'd0, C_LDX = 3'd1, C_ST = 3'd2, C_STX = 3'd3,
                           C_ALU = 3'd4, C_JMP = 3'd5, C_RET = 3'd6, C_MISC = 3'd7;
    localparam logic [2:0] M_IMM = 3'd0, M_ABS = 3'd1, M_IND = 3'd2, M_MEM = 3'd3,
                           M_LEN = 3'd4, M_MSH = 3'd5;
    localparam logic [2:0] A_IMM = 3'd0, A_PKT = 3'd1, A_MEM = 3'd2, A_LEN = 3'd3, A_X = 3'd4, A_ALU = 3'd5;
    localparam logic [2:0] X_IMM = 3'd0, X_PKT = 3'd1, X_MEM = 3'd2, X_LEN = 3'd3, X_A = 3'd4, X_MSH = 3'd5;
    localparam logic [1:0] PC_PLUS_1 = 2'd0, PC_PLUS_IMM = 2'd1, PC_PLUS_JT = 2'd2, PC_PLUS_JF = 2'd3;
    localparam logic [1:0] DST_A = 2'd0, DST_X = 2'd1, DST_MSH = 2'd2;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] insn_count;
    logic [TMO_W-1:0] wait_cnt;
    logic [1:0]       dest_q, dec_dest;
    logic [3:0]       flags_q;              // {set, eq, gt, ge} captured in DECODE
    logic             accept_q, reject_q, overrun_q, mem_err_q;
    logic             v_accept, v_reject, v_overrun, v_mem_err;
    logic             dec_ill, dec_pkt, dec_alu, dec_cond, dec_ret, ret_ok;
    logic             at_budget, tmo_hit;
    logic [2:0]       a_sel, x_sel;
    logic [1:0]       pc_sel;
    logic             a_en, x_en, pc_en, pc_rst, regfile_wr_en, inst_rd, pkt_rd;

    wire [2:0] cls  = bus.opcode[2:0];
    wire [2:0] mode = bus.opcode[7:5];
    wire [3:0] op   = bus.opcode[7:4];
    wire [1:0] rval = bus.opcode[4:3];

    function automatic logic cond_eval(input logic [3:0] jop, input logic [3:0] f);
        case (jop)
            4'd1:    return f[2];   // JEQ
            4'd2:    return f[1];   // JGT
            4'd3:    return f[0];   // JGE
            4'd4:    return f[3];   // JSET
            default: return 1'b0;
        endcase
    endfunction

    assign at_budget = (insn_count == CNT_W'(MAX_INSNS));
    assign tmo_hit   = (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));

    // Instruction classification; the upper opcode byte is reserved and must be zero.
    always_comb begin
        dec_ill  = |bus.opcode[15:8];
        dec_pkt  = 1'b0;
        dec_dest = DST_A;
        dec_alu  = 1'b0;
        dec_cond = 1'b0;
        dec_ret  = 1'b0;
        case (cls)
            C_LD: case (mode)
                M_IMM, M_MEM, M_LEN: ;
                M_ABS, M_IND:        dec_pkt = 1'b1;
                default:             dec_ill = 1'b1;
            endcase
            C_LDX: case (mode)
                M_IMM, M_MEM, M_LEN: ;
                M_ABS, M_IND: begin dec_pkt = 1'b1; dec_dest = DST_X;   end
                M_MSH:        begin dec_pkt = 1'b1; dec_dest = DST_MSH; end
                default:      dec_ill = 1'b1;
            endcase
            C_ST, C_STX: ;
            C_ALU: if (op > 4'hA) dec_ill = 1'b1; else dec_alu = 1'b1;
            C_JMP: if (op > 4'd4) dec_ill = 1'b1; else dec_cond = (op != 4'd0);
            C_RET: if (rval == 2'd3) dec_ill = 1'b1; else dec_ret = 1'b1;
            default: if (bus.opcode[7:3] != 5'h00 && bus.opcode[7:3] != 5'h10) dec_ill = 1'b1;
        endcase
        case (rval)
            2'd0:    ret_ok = !bus.imm_is_zero;
            2'd1:    ret_ok = !bus.X_is_zero;
            default: ret_ok = !bus.A_is_zero;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nxt;
    end

    // Next state plus the verdict to load when entering DONE.
    always_comb begin
        state_nxt = state;
        v_accept  = 1'b0;
        v_reject  = 1'b0;
        v_overrun = 1'b0;
        v_mem_err = 1'b0;
        case (state)
            S_RESET:      if (bus.mem_ready) state_nxt = S_FETCH;
            S_FETCH:      if (at_budget) begin
                              state_nxt = S_DONE; v_reject = 1'b1; v_overrun = 1'b1;
                          end else state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: if (bus.inst_mem_valid) state_nxt = S_DECODE;
            S_DECODE:     if (dec_ill) begin
                              state_nxt = S_DONE; v_reject = 1'b1;
                          end else if (dec_ret) begin
                              state_nxt = S_DONE; v_accept = ret_ok; v_reject = !ret_ok;
                          end else if (dec_pkt)  state_nxt = S_PMEM_WAIT;
                          else if (dec_alu)      state_nxt = S_WRITE_ALU;
                          else if (dec_cond && PESSIMISTIC != 0) state_nxt = S_COND_JMP;
                          else                   state_nxt = S_FETCH;
            // A valid arriving on the timeout cycle still completes the load.
            S_PMEM_WAIT:  if (bus.packet_mem_valid) state_nxt = S_FETCH;
                          else if (tmo_hit) begin
                              state_nxt = S_DONE; v_reject = 1'b1; v_mem_err = 1'b1;
                          end
            S_WRITE_ALU, S_COND_JMP: state_nxt = S_FETCH;
            S_DONE:       if (bus.verdict_ack) state_nxt = S_RESET;
            default:      state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        a_sel = 3'd0; x_sel = 3'd0; pc_sel = PC_PLUS_1;
        a_en = 1'b0; x_en = 1'b0; pc_en = 1'b0; pc_rst = 1'b0;
        regfile_wr_en = 1'b0; inst_rd = 1'b0; pkt_rd = 1'b0;
        case (state)
            S_RESET: pc_rst = 1'b1;
            S_FETCH: if (!at_budget) begin inst_rd = 1'b1; pc_en = 1'b1; pc_sel = PC_PLUS_1; end
            S_DECODE: if (!dec_ill) begin
                case (cls)
                    C_LD: case (mode)
                        M_IMM:        begin a_en = 1'b1; a_sel = A_IMM; end
                        M_MEM:        begin a_en = 1'b1; a_sel = A_MEM; end
                        M_LEN:        begin a_en = 1'b1; a_sel = A_LEN; end
                        default:      pkt_rd = 1'b1;
                    endcase
                    C_LDX: case (mode)
                        M_IMM:        begin x_en = 1'b1; x_sel = X_IMM; end
                        M_MEM:        begin x_en = 1'b1; x_sel = X_MEM; end
                        M_LEN:        begin x_en = 1'b1; x_sel = X_LEN; end
                        default:      pkt_rd = 1'b1;
                    endcase
                    C_ST, C_STX: regfile_wr_en = 1'b1;
                    C_MISC: if (bus.opcode[7]) begin a_en = 1'b1; a_sel = A_X; end
                            else               begin x_en = 1'b1; x_sel = X_A; end
                    C_JMP: if (!dec_cond) begin
                               pc_en = 1'b1; pc_sel = PC_PLUS_IMM;
                           end else if (PESSIMISTIC == 0) begin
                               pc_en  = 1'b1;
                               pc_sel = cond_eval(op, {bus.set, bus.eq, bus.gt, bus.ge}) ? PC_PLUS_JT : PC_PLUS_JF;
                           end
                    default: ;
                endcase
            end
            S_PMEM_WAIT: if (bus.packet_mem_valid) begin
                case (dest_q)
                    DST_A:   begin a_en = 1'b1; a_sel = A_PKT; end
                    DST_X:   begin x_en = 1'b1; x_sel = X_PKT; end
                    default: begin x_en = 1'b1; x_sel = X_MSH; end
                endcase
            end
            S_WRITE_ALU: begin a_en = 1'b1; a_sel = A_ALU; end
            S_COND_JMP: begin
                pc_en  = 1'b1;
                pc_sel = cond_eval(op, flags_q) ? PC_PLUS_JT : PC_PLUS_JF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_count <= '0;
            wait_cnt   <= '0;
            dest_q     <= DST_A;
            flags_q    <= '0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            overrun_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            if (state == S_RESET)
                insn_count <= '0;
            else if (state == S_DECODE && !at_budget)
                insn_count <= insn_count + 1'b1;
            if (state == S_DECODE) begin
                wait_cnt <= '0;
                flags_q  <= {bus.set, bus.eq, bus.gt, bus.ge};
                if (dec_pkt) dest_q <= dec_dest;
            end else if (state == S_PMEM_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == S_DONE) begin
                if (bus.verdict_ack) begin
                    accept_q <= 1'b0; reject_q <= 1'b0; overrun_q <= 1'b0; mem_err_q <= 1'b0;
                end
            end else if (state_nxt == S_DONE) begin
                accept_q <= v_accept; reject_q <= v_reject; overrun_q <= v_overrun; mem_err_q <= v_mem_err;
            end
        end
    end

    assign bus.A_sel            = a_sel;
    assign bus.X_sel            = x_sel;
    assign bus.PC_sel           = pc_sel;
    assign bus.A_en             = a_en;
    assign bus.X_en             = x_en;
    assign bus.PC_en            = pc_en;
    assign bus.PC_rst           = pc_rst;
    assign bus.regfile_wr_en    = regfile_wr_en;
    assign bus.inst_mem_rd_en   = inst_rd;
    assign bus.packet_mem_rd_en = pkt_rd;
    assign bus.addr_sel         = (mode == M_IND);
    assign bus.regfile_sel      = (cls == C_STX);
    assign bus.B_sel            = bus.opcode[3];
    assign bus.ALU_sel          = bus.opcode[7:4];
    assign bus.transfer_sz      = bus.opcode[4:3];
    assign bus.accept           = accept_q;
    assign bus.reject           = reject_q;
    assign bus.overrun          = overrun_q;
    assign bus.mem_err          = mem_err_q;
    assign bus.insn_count       = insn_count;
endmodule

// File: tb/tb_bpfvm_ctrl_mc.sv
// Directed bench for bpfvm_ctrl_mc: two instances (optimistic and pessimistic jumps, budget 16)
// share one stimulus stream; inputs change just after the falling edge, outputs are checked 1 unit later.
module tb_bpfvm_ctrl_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] opcode = '0;
    logic        set_f = 0, eq_f = 0, gt_f = 0, ge_f = 0;
    logic        a_zero = 0, x_zero = 0, imm_zero = 0;
    logic        mem_ready = 0, inst_mem_valid = 0, packet_mem_valid = 0, verdict_ack = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    bpfvm_ctrl_mc_if #(.CNT_W(16)) if0 ();
    bpfvm_ctrl_mc_if #(.CNT_W(16)) if1 ();

    assign if0.opcode = opcode;            assign if1.opcode = opcode;
    assign if0.set = set_f;                assign if1.set = set_f;
    assign if0.eq = eq_f;                  assign if1.eq = eq_f;
    assign if0.gt = gt_f;                  assign if1.gt = gt_f;
    assign if0.ge = ge_f;                  assign if1.ge = ge_f;
    assign if0.A_is_zero = a_zero;         assign if1.A_is_zero = a_zero;
    assign if0.X_is_zero = x_zero;         assign if1.X_is_zero = x_zero;
    assign if0.imm_is_zero = imm_zero;     assign if1.imm_is_zero = imm_zero;
    assign if0.mem_ready = mem_ready;      assign if1.mem_ready = mem_ready;
    assign if0.inst_mem_valid = inst_mem_valid;     assign if1.inst_mem_valid = inst_mem_valid;
    assign if0.packet_mem_valid = packet_mem_valid; assign if1.packet_mem_valid = packet_mem_valid;
    assign if0.verdict_ack = verdict_ack;  assign if1.verdict_ack = verdict_ack;

    bpfvm_ctrl_mc #(.PESSIMISTIC(0), .MAX_INSNS(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bpfvm_ctrl_mc #(.PESSIMISTIC(1), .MAX_INSNS(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and drop single-cycle inputs.
    task automatic nxt();
        @(negedge clk);
        mem_ready = 0; inst_mem_valid = 0; packet_mem_valid = 0; verdict_ack = 0;
    endtask

    task automatic do_reset();
        nxt(); rst_n = 0;
        set_f = 0; eq_f = 0; gt_f = 0; ge_f = 0;
        nxt(); rst_n = 1;
    endtask

    // From RESET: the following cycle is FETCH.
    task automatic start();
        nxt(); mem_ready = 1;
    endtask

    // FETCH, FETCH_WAIT (1-cycle memory), then leave the bench in the DECODE cycle.
    task automatic fetch(input logic [15:0] op);
        nxt(); #1 check("fetch_strobe", if0.inst_mem_rd_en, 1);
        nxt(); opcode = op; inst_mem_valid = 1;
        nxt(); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, rd_cnt, dec_cnt, stray;
        logic prev_rd, done;

        // Reset state while rst_n is held low
        #1;
        check("rst_pc_rst", if0.PC_rst, 1);
        check("rst_verdict", {if0.accept, if0.reject, if0.overrun, if0.mem_err}, 4'b0000);
        check("rst_count", if0.insn_count, 0);
        nxt(); rst_n = 1;

        // Basic RET: ld #5 ; ret a
        start(); #1 check("reset_state", if0.PC_rst, 1);
        fetch(16'h0000);
        check("ld_imm_A_en", {if0.A_en, if0.X_en}, 2'b10);
        check("ld_imm_A_sel", if0.A_sel, 0);
        a_zero = 0;
        fetch(16'h0016);
        check("ret_count", if0.insn_count, 1);
        check("ret_not_yet", if0.accept, 0);
        verdict_ack = 1;                       // entry-cycle ack must be ignored
        nxt(); #1 check("ret_accept", {if0.accept, if0.reject}, 2'b10);
        check("ret_count2", if0.insn_count, 2);
        nxt(); #1 check("verdict_held", {if0.accept, if0.PC_rst}, 2'b10);
        verdict_ack = 1;
        nxt(); #1 check("ack_clear", {if0.accept, if0.PC_rst}, 2'b01);

        // Pure opcode decodes
        opcode = 16'h005c; #1;
        check("alu_sel", if0.ALU_sel, 5);
        check("b_sel", if0.B_sel, 1);
        opcode = 16'h0048; #1;
        check("addr_sel_ind", {if0.addr_sel, if0.transfer_sz}, 3'b101);
        opcode = 16'h0003; #1 check("regfile_sel_stx", if0.regfile_sel, 1);

        // Packet load with 10 stall cycles
        do_reset(); start(); fetch(16'h0028);
        check("ldh_pkt_rd", if0.packet_mem_rd_en, 1);
        check("ldh_sz", if0.transfer_sz, 1);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            nxt(); #1;
            stray += int'(if0.packet_mem_rd_en) + int'(if0.A_en) + int'(if0.inst_mem_rd_en);
        end
        check("stall_quiet", stray, 0);
        nxt(); packet_mem_valid = 1; #1;
        check("pkt_A_en", {if0.A_en, if0.X_en}, 2'b10);
        check("pkt_A_sel", if0.A_sel, 1);
        nxt(); #1 check("pkt_then_fetch", if0.inst_mem_rd_en, 1);

        // ldx msh: X written with MSH select
        do_reset(); start(); fetch(16'h00b1);
        check("msh_pkt_rd", {if0.packet_mem_rd_en, if0.transfer_sz}, 3'b110);
        nxt(); packet_mem_valid = 1; #1;
        check("msh_X_en", {if0.A_en, if0.X_en}, 2'b01);
        check("msh_X_sel", if0.X_sel, 5);

        // Packet-memory timeout
        do_reset(); start(); fetch(16'h0020);
        n = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            nxt(); #1; n++;
            if (if0.reject) done = 1;
        end
        check("tmo_seen", done, 1);
        check("tmo_cycles", n - 1, 255);
        check("tmo_flags", {if0.accept, if0.reject, if0.overrun, if0.mem_err}, 4'b0101);
        rst_n = 0; #1;
        check("async_verdict_clear", {if0.reject, if0.mem_err}, 2'b00);

        // Valid on the timeout cycle wins
        do_reset(); start(); fetch(16'h0020);
        repeat (254) nxt();
        nxt(); packet_mem_valid = 1; #1 check("tmo_edge_A_en", if0.A_en, 1);
        nxt(); #1 check("tmo_edge_fetch", {if0.reject, if0.inst_mem_rd_en}, 2'b01);

        // ALU, store, illegal
        do_reset(); start(); fetch(16'h0004);
        check("alu_decode_quiet", if0.A_en, 0);
        nxt(); #1 check("write_alu", {if0.A_en, if0.A_sel}, 4'b1101);
        fetch(16'h0002);
        check("st_wr", {if0.regfile_wr_en, if0.regfile_sel}, 2'b10);
        fetch(16'h000f);
        nxt(); #1 check("illegal", {if0.accept, if0.reject, if0.overrun, if0.mem_err}, 4'b0100);

        // Instruction budget: ja -1 forever, 1-cycle instruction memory
        do_reset(); start();
        rd_cnt = 0; dec_cnt = 0; prev_rd = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            nxt();
            if (prev_rd) begin inst_mem_valid = 1; opcode = 16'h0005; end
            #1;
            rd_cnt  += int'(if0.inst_mem_rd_en);
            dec_cnt += int'(if0.PC_en && if0.PC_sel == 2'd1);
            prev_rd = if0.inst_mem_rd_en;
            if (if0.reject) done = 1;
        end
        check("budget_done", done, 1);
        check("budget_rd", rd_cnt, 16);
        check("budget_decodes", dec_cnt, 16);
        check("budget_flags", {if0.accept, if0.reject, if0.overrun, if0.mem_err}, 4'b0110);
        check("budget_count", if0.insn_count, 16);

        // Conditional jump, eq=1: taken
        do_reset(); start(); eq_f = 1; fetch(16'h0015);
        check("jeq_p0_decode", {if0.PC_en, if0.PC_sel}, 3'b110);
        check("jeq_p1_decode", {if1.PC_en, if1.PC_sel}, 3'b000);
        nxt(); eq_f = 0; #1;                   // COND_JMP must use the flag captured in DECODE
        check("jeq_p1_cond", {if1.PC_en, if1.PC_sel}, 3'b110);
        check("jeq_fetch_split", {if0.inst_mem_rd_en, if1.inst_mem_rd_en}, 2'b10);

        // Conditional jump, eq=0: not taken
        do_reset(); start(); eq_f = 0; fetch(16'h0015);
        check("jne_p0_decode", {if0.PC_en, if0.PC_sel}, 3'b111);
        nxt(); eq_f = 1; #1;
        check("jne_p1_cond", {if1.PC_en, if1.PC_sel}, 3'b111);

        // Asynchronous reset in FETCH_WAIT
        do_reset(); start();
        nxt(); nxt(); #1 check("fw_quiet", if0.inst_mem_rd_en, 0);
        #2 rst_n = 0;
        #1 check("async_rst", {if0.PC_rst, if0.inst_mem_rd_en}, 2'b10);
        nxt(); rst_n = 1; opcode = 16'h0000; inst_mem_valid = 1;
        #1 check("late_valid_rst", if0.PC_rst, 1);
        nxt(); #1 check("no_decode", {if0.PC_rst, if0.A_en}, 2'b10);
        check("no_decode_count", if0.insn_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
